// File: rtl/bram_wr_if.sv
// Stream input plus Port-B style BRAM bus of the block RAM writer.
// The slave modport is the writer side and the master modport is the stream source / RAM side.
interface bram_wr_if;
  logic [31:0] din;
  logic        din_valid;
  logic        din_ready;
  logic        ram_clk;
  logic        ram_rst;
  logic        ram_en;
  logic [3:0]  ram_we;
  logic [31:0] ram_addr;
  logic [31:0] ram_wr_data;
  logic [31:0] ram_rd_data;

  modport slave (
    input  din, din_valid, ram_rd_data,
    output din_ready, ram_clk, ram_rst, ram_en, ram_we, ram_addr, ram_wr_data
  );

  modport master (
    output din, din_valid, ram_rd_data,
    input  din_ready, ram_clk, ram_rst, ram_en, ram_we, ram_addr, ram_wr_data
  );
endinterface

// File: rtl/bram_wr.sv
// Writes a 32-bit valid/ready stream into a BRAM from a latched byte address and length.
// Defining BRAM_WR_PATTERN_EN adds pat_mode, which selects an internal word-index data source.
module bram_wr (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start_wr,
  input  logic [31:0] start_addr,
  input  logic [31:0] wr_len,
`ifdef BRAM_WR_PATTERN_EN
  input  logic        pat_mode,
`endif
  output logic        busy,
  output logic        wr_done,
  bram_wr_if.slave    bus
);

  typedef enum logic [1:0] {IDLE, WRITE, DONE} state_t;

  state_t      state_q, state_d;
  logic        d0_q, d1_q;
  logic [31:0] addr_q, addr_d;
  logic [29:0] words_q, words_d;
  logic        ram_en_q, ram_en_d;
  logic [3:0]  ram_we_q, ram_we_d;
  logic [31:0] ram_addr_q, ram_addr_d;
  logic [31:0] ram_wr_data_q, ram_wr_data_d;
  logic        wr_done_q, wr_done_d;
  logic        pos_start;
  logic        accept;
  logic [31:0] wdata;

`ifdef BRAM_WR_PATTERN_EN
  logic        pat_q, pat_d;
  logic [31:0] idx_q, idx_d;

  assign bus.din_ready = (state_q == WRITE) & ~pat_q;
  assign accept        = (state_q == WRITE) & (pat_q | bus.din_valid);
  assign wdata         = pat_q ? idx_q : bus.din;
`else
  assign bus.din_ready = (state_q == WRITE);
  assign accept        = bus.din_valid & bus.din_ready;
  assign wdata         = bus.din;
`endif

  assign pos_start       = d0_q & ~d1_q;
  assign busy            = (state_q != IDLE);
  assign wr_done         = wr_done_q;
  assign bus.ram_clk     = clk;
  assign bus.ram_rst     = 1'b0;
  assign bus.ram_en      = ram_en_q;
  assign bus.ram_we      = ram_we_q;
  assign bus.ram_addr    = ram_addr_q;
  assign bus.ram_wr_data = ram_wr_data_q;

  // Read data and the sub-word length bits have no use in a write-only engine.
  logic unused_ok;
  assign unused_ok = ^bus.ram_rd_data ^ ^wr_len[1:0];

  always_comb begin
    state_d       = state_q;
    addr_d        = addr_q;
    words_d       = words_q;
    ram_en_d      = 1'b0;
    ram_we_d      = 4'h0;
    ram_addr_d    = ram_addr_q;
    ram_wr_data_d = ram_wr_data_q;
    wr_done_d     = 1'b0;
`ifdef BRAM_WR_PATTERN_EN
    pat_d         = pat_q;
    idx_d         = idx_q;
`endif
    case (state_q)
      IDLE: begin
        if (pos_start) begin
          addr_d  = start_addr;
          words_d = wr_len[31:2];
`ifdef BRAM_WR_PATTERN_EN
          pat_d   = pat_mode;
          idx_d   = 32'd0;
`endif
          state_d = (wr_len[31:2] == 30'd0) ? DONE : WRITE;
        end
      end
      WRITE: begin
        if (accept) begin
          ram_en_d      = 1'b1;
          ram_we_d      = 4'hF;
          ram_addr_d    = addr_q;
          ram_wr_data_d = wdata;
          addr_d        = addr_q + 32'd4;
          words_d       = words_q - 30'd1;
`ifdef BRAM_WR_PATTERN_EN
          idx_d         = idx_q + 32'd1;
`endif
          if (words_q == 30'd1) state_d = DONE;
        end
      end
      DONE: begin
        ram_addr_d = 32'd0;
        wr_done_d  = 1'b1;
        state_d    = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      d0_q          <= 1'b0;
      d1_q          <= 1'b0;
      addr_q        <= 32'd0;
      words_q       <= 30'd0;
      ram_en_q      <= 1'b0;
      ram_we_q      <= 4'h0;
      ram_addr_q    <= 32'd0;
      ram_wr_data_q <= 32'd0;
      wr_done_q     <= 1'b0;
`ifdef BRAM_WR_PATTERN_EN
      pat_q         <= 1'b0;
      idx_q         <= 32'd0;
`endif
    end else begin
      state_q       <= state_d;
      d0_q          <= start_wr;
      d1_q          <= d0_q;
      addr_q        <= addr_d;
      words_q       <= words_d;
      ram_en_q      <= ram_en_d;
      ram_we_q      <= ram_we_d;
      ram_addr_q    <= ram_addr_d;
      ram_wr_data_q <= ram_wr_data_d;
      wr_done_q     <= wr_done_d;
`ifdef BRAM_WR_PATTERN_EN
      pat_q         <= pat_d;
      idx_q         <= idx_d;
`endif
    end
  end

endmodule

// File: doc/bram_wr.md
# bram_wr

Fills a PL block RAM from a 32-bit valid/ready data stream, starting at a programmed byte address for a programmed byte length. Triggered by a rising edge on `start_wr` from the PS-side control registers; drives the Port-B style BRAM interface (`ram_*`) of the same RAM that the PS and the BRAM read engine share. Raises a one-cycle `wr_done` pulse when the last word has been written.

## Interface
Parameters: none.
- `clk`  in  1  system clock; also forwarded as `ram_clk`.
- `rst_n`  in  1  asynchronous, active-low reset.
- `start_wr`  in  1  write request; level from a register, rising edge starts a transfer.
- `start_addr`  in  32  first byte address; latched on accepted start.
- `wr_len`  in  32  transfer length in bytes; latched on accepted start; bits [1:0] ignored.
- `din`  in  32  stream data word.
- `din_valid`  in  1  `din` is valid.
- `din_ready`  out  1  block accepts a word this cycle.
- `busy`  out  1  transfer in progress.
- `wr_done`  out  1  one-cycle completion pulse.
- `ram_clk`  out  1  = `clk`.
- `ram_rst`  out  1  constant 0.
- `ram_en`  out  1  RAM enable.
- `ram_we`  out  4  byte write enables.
- `ram_addr`  out  32  RAM byte address.
- `ram_wr_data`  out  32  RAM write data.
- `ram_rd_data`  in  32  unused; present for port completeness.

## Operation
- Edge detect: `start_wr` registered twice (d0, d1); `pos_start = d0 & ~d1`. Edge detector runs in all states; `pos_start` outside IDLE is ignored (no queueing).
- States: IDLE, WRITE, DONE.
- IDLE: on `pos_start`, latch `addr <= start_addr`, `words <= wr_len[31:2]` (30 bits). If `wr_len[31:2] == 0` go to DONE (no writes), else go to WRITE.
- WRITE: `din_ready = 1` (combinational from state). On each accept (`din_valid & din_ready`): `ram_en <= 1`, `ram_we <= 4'hF`, `ram_addr <= addr`, `ram_wr_data <= din`, `addr <= addr + 4`, `words <= words - 1`. Cycle without accept: `ram_en <= 0`, `ram_we <= 0`, `ram_addr`/`ram_wr_data` hold. Accept with `words == 1` -> DONE.
- DONE: `ram_en <= 0`, `ram_we <= 0`, `ram_addr <= 0`, `wr_done <= 1`, -> IDLE. `wr_done` cleared on the following edge.
- `busy = (state != IDLE)`; `din_ready` is 0 in IDLE and DONE.
- Address arithmetic modulo 2^32; wrap from 0xFFFFFFFC to 0x00000000 without error.
- Reset (any time, including mid-transfer): state IDLE, `ram_en 0`, `ram_we 0`, `ram_addr 0`, `ram_wr_data 0`, `wr_done 0`, `busy 0`, `din_ready 0`, d0/d1 0, counters 0. Partial transfer abandoned; no done pulse.

## Timing
- `start_wr` first sampled high at edge k -> `pos_start` high in cycle k..k+1 -> state WRITE after edge k+1; `din_ready` high from k+1.
- Accept at edge m -> BRAM write presented on `ram_*` during cycle m..m+1 (one-cycle registered latency).
- Full-rate: one word per cycle when `din_valid` held high; N words take N cycles in WRITE.
- Last accept at edge m -> DONE during m..m+1; `wr_done` and `ram_en = 0` during m+1..m+2; `busy` low from m+1.
- Zero length: `wr_done` high two cycles after `pos_start` edge, no `ram_en` activity.

## Configuration
- `BRAM_WR_PATTERN_EN` defined: adds input `pat_mode` (1 bit), latched with `start_addr`. If latched 1, data source is internal word index (0, 1, 2, ...), one write every WRITE cycle, `din` ignored, `din_ready` held 0; otherwise stream mode as above.
- Not defined: no `pat_mode` port; stream mode only.

## Test plan
- Basic: `start_addr=0x0`, `wr_len=16`, `din_valid` held 1, din 0xA0..0xA3 -> four writes at 0x0,0x4,0x8,0xC with `ram_we=4'hF`, data 0xA0..0xA3 on consecutive cycles, one `wr_done` pulse, `ram_addr` returns 0.
- Backpressure: `wr_len=12`, `din_valid` toggled 1,0,0,1,0,1 -> exactly three writes at 0x0/0x4/0x8, `ram_en=0` on non-accept cycles, `wr_done` one cycle after last write.
- Zero/odd length: `wr_len=0` -> no `ram_en`, `wr_done` pulse; `wr_len=7` -> one write only.
- Wrap and retrigger: `start_addr=0xFFFFFFF8`, `wr_len=16` -> addresses 0xFFFFFFF8, 0xFFFFFFFC, 0x0, 0x4; second `start_wr` edge during transfer ignored (exactly four writes).
- Reset mid-transfer: `wr_len=64`, assert `rst_n=0` after 5 accepts -> all outputs 0 immediately, no `wr_done`; new start after release writes from fresh `start_addr`.
- With `BRAM_WR_PATTERN_EN`, `pat_mode=1`, `wr_len=16`, `start_addr=0x100` -> data 0,1,2,3 at 0x100..0x10C on four consecutive cycles, `din_ready` stays 0.
